excp_ctrl: RTL and testbench

- Commit-stage exception/interrupt sequencer for the dual-issue pipeline; sole driver of the CSR file's trap-entry and trap-return interface.
- Each cycle it:
  - arbitrates between the two commit slots and the pending interrupt;
  - drives raise_excp/excp_type/pc_in and the BADV/VPPN capture strobes;
  - issues the frontend redirect;
  - sequences the pipeline flush and the IDLE wait state.

---
 rtl/excp_ctrl_pkg.sv | 43 ++++
 rtl/excp_ctrl_if.sv | 42 ++++
 rtl/excp_ctrl_arb.sv | 62 ++++++
 rtl/excp_ctrl.sv | 117 +++++++++++
 tb/tb_excp_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/excp_ctrl_pkg.sv
// Shared exception codes, FSM state encoding and CSR-capture helpers for the
// commit-stage exception sequencer.
package excp_ctrl_pkg;

    typedef struct packed {
        logic [5:0] ecode;
        logic [8:0] esubcode;
    } excp_t;

    localparam excp_t INT  = '{6'h00, 9'h000};
    localparam excp_t PIL  = '{6'h01, 9'h000};
    localparam excp_t PIS  = '{6'h02, 9'h000};
    localparam excp_t PIF  = '{6'h03, 9'h000};
    localparam excp_t PME  = '{6'h04, 9'h000};
    localparam excp_t PPI  = '{6'h07, 9'h000};
    localparam excp_t ADEF = '{6'h08, 9'h000};
    localparam excp_t ADEM = '{6'h08, 9'h001};
    localparam excp_t ALE  = '{6'h09, 9'h000};
    localparam excp_t SYS  = '{6'h0b, 9'h000};
    localparam excp_t BRK  = '{6'h0c, 9'h000};
    localparam excp_t INE  = '{6'h0d, 9'h000};
    localparam excp_t IPE  = '{6'h0e, 9'h000};
    localparam excp_t TLBR = '{6'h3f, 9'h000};
    // Pseudo-code that the CSR file decodes as trap return; never a real Ecode.
    localparam excp_t ERTN = '{6'h3e, 9'h000};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_IDLE  = 2'd2
    } state_e;

    function automatic logic excp_sets_badv(input excp_t t);
        return t.ecode inside {PIL.ecode, PIS.ecode, PIF.ecode, PME.ecode, PPI.ecode,
                               ADEF.ecode, ALE.ecode, TLBR.ecode};
    endfunction

    function automatic logic excp_sets_vppn(input excp_t t);
        return t.ecode inside {PIL.ecode, PIS.ecode, PIF.ecode, PME.ecode, PPI.ecode,
                               TLBR.ecode};
    endfunction

endpackage

// File: rtl/excp_ctrl_if.sv
// Commit-stage / CSR / frontend bundle seen by the exception sequencer.
// master = the sequencer itself, slave = the pipeline/CSR environment.
interface excp_ctrl_if
    import excp_ctrl_pkg::*;
;
    logic [1:0]        slot_valid;
    logic [1:0][31:0]  slot_pc;
    logic [1:0]        slot_excp;
    excp_t [1:0]       slot_excp_type;
    logic [1:0][31:0]  slot_badv;
    logic [1:0]        slot_ertn;
    logic [1:0]        slot_idle;
    logic              csr_interrupt;
    logic [31:0]       csr_pc_out;
    logic [1:0]        commit_en;
    logic              raise_excp;
    excp_t             excp_type;
    logic [31:0]       pc_in;
    logic              badv_we;
    logic [31:0]       badv_data;
    logic              vppn_we;
    logic [18:0]       vppn_data;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              flush;
    logic              stall;

    modport master (
        input  slot_valid, slot_pc, slot_excp, slot_excp_type, slot_badv,
               slot_ertn, slot_idle, csr_interrupt, csr_pc_out,
        output commit_en, raise_excp, excp_type, pc_in, badv_we, badv_data,
               vppn_we, vppn_data, redirect_valid, redirect_pc, flush, stall
    );

    modport slave (
        output slot_valid, slot_pc, slot_excp, slot_excp_type, slot_badv,
               slot_ertn, slot_idle, csr_interrupt, csr_pc_out,
        input  commit_en, raise_excp, excp_type, pc_in, badv_we, badv_data,
               vppn_we, vppn_data, redirect_valid, redirect_pc, flush, stall
    );

endinterface

// File: rtl/excp_ctrl_arb.sv
// Combinational priority picker: interrupt > slot0 excp > slot0 ertn > slot0 idle
// > slot1 excp/ertn > slot1 idle > plain commit.
module excp_arb
    import excp_ctrl_pkg::*;
#(
    parameter int unsigned IDLE_RESUME_OFFSET = 4
) (
    input  logic [1:0]        slot_valid_i,
    input  logic [1:0][31:0]  slot_pc_i,
    input  logic [1:0]        slot_excp_i,
    input  excp_t [1:0]       slot_excp_type_i,
    input  logic [1:0][31:0]  slot_badv_i,
    input  logic [1:0]        slot_ertn_i,
    input  logic [1:0]        slot_idle_i,
    input  logic              csr_interrupt_i,
    output logic              trap_o,
    output excp_t             trap_type_o,
    output logic [31:0]       trap_pc_o,
    output logic [31:0]       trap_badv_o,
    output logic              go_idle_o,
    output logic [31:0]       idle_pc_o,
    output logic [1:0]        commit_en_o
);
    localparam logic [31:0] RESUME_OFS = 32'(IDLE_RESUME_OFFSET);

    always_comb begin
        trap_o      = 1'b0;
        trap_type_o = INT;
        trap_pc_o   = slot_pc_i[0];
        trap_badv_o = slot_badv_i[0];
        go_idle_o   = 1'b0;
        idle_pc_o   = slot_pc_i[0] + RESUME_OFS;
        commit_en_o = {slot_valid_i[1] & slot_valid_i[0], slot_valid_i[0]};
        if (slot_valid_i[0] && csr_interrupt_i) begin
            trap_o      = 1'b1;
            commit_en_o = 2'b00;
        end else if (slot_valid_i[0] && slot_excp_i[0]) begin
            trap_o      = 1'b1;
            trap_type_o = slot_excp_type_i[0];
            commit_en_o = 2'b00;
        end else if (slot_valid_i[0] && slot_ertn_i[0]) begin
            trap_o      = 1'b1;
            trap_type_o = ERTN;
            commit_en_o = 2'b00;
        end else if (slot_valid_i[0] && slot_idle_i[0]) begin
            // slot1 is dropped here and refetched after wake-up
            go_idle_o   = 1'b1;
            commit_en_o = 2'b01;
        end else if (slot_valid_i[1] && (slot_excp_i[1] || slot_ertn_i[1])) begin
            trap_o      = 1'b1;
            trap_type_o = slot_excp_i[1] ? slot_excp_type_i[1] : ERTN;
            trap_pc_o   = slot_pc_i[1];
            trap_badv_o = slot_badv_i[1];
            commit_en_o = 2'b01;
        end else if (slot_valid_i[1] && slot_idle_i[1]) begin
            go_idle_o   = 1'b1;
            idle_pc_o   = slot_pc_i[1] + RESUME_OFS;
            commit_en_o = 2'b11;
        end
    end

endmodule

// File: rtl/excp_ctrl.sv
// Commit-stage exception/interrupt sequencer: drives CSR trap entry/return,
// frontend redirect, pipeline flush and the IDLE wait state.
module excp_ctrl
    import excp_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES       = 2,
    parameter int unsigned IDLE_RESUME_OFFSET = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    excp_ctrl_if.master ctrl_if
);
    localparam int          CNT_W      = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned FLUSH_INIT = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [31:0]        idle_pc_q, idle_pc_d;

    logic               arb_trap, arb_go_idle;
    excp_t              arb_type;
    logic [31:0]        arb_pc, arb_badv, arb_idle_pc;
    logic [1:0]         arb_commit_en;
    logic               trap_run, trap_idle;

    excp_arb #(.IDLE_RESUME_OFFSET(IDLE_RESUME_OFFSET)) u_arb (
        .slot_valid_i     (ctrl_if.slot_valid),
        .slot_pc_i        (ctrl_if.slot_pc),
        .slot_excp_i      (ctrl_if.slot_excp),
        .slot_excp_type_i (ctrl_if.slot_excp_type),
        .slot_badv_i      (ctrl_if.slot_badv),
        .slot_ertn_i      (ctrl_if.slot_ertn),
        .slot_idle_i      (ctrl_if.slot_idle),
        .csr_interrupt_i  (ctrl_if.csr_interrupt),
        .trap_o           (arb_trap),
        .trap_type_o      (arb_type),
        .trap_pc_o        (arb_pc),
        .trap_badv_o      (arb_badv),
        .go_idle_o        (arb_go_idle),
        .idle_pc_o        (arb_idle_pc),
        .commit_en_o      (arb_commit_en)
    );

    assign trap_run  = (state_q == ST_RUN) && arb_trap;
    assign trap_idle = (state_q == ST_IDLE) && ctrl_if.csr_interrupt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            idle_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            idle_pc_q   <= idle_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        idle_pc_d   = idle_pc_q;
        if (trap_run || trap_idle) begin
            // the trap cycle itself is the first flush cycle
            state_d     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
            flush_cnt_d = CNT_W'(FLUSH_INIT);
        end else begin
            unique case (state_q)
                ST_RUN: if (arb_go_idle) begin
                    state_d   = ST_IDLE;
                    idle_pc_d = arb_idle_pc;
                end
                ST_FLUSH: if (flush_cnt_q == '0) state_d = ST_RUN;
                          else flush_cnt_d = flush_cnt_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    excp_t       sel_type;
    logic [31:0] sel_badv;

    always_comb begin
        sel_type               = trap_idle ? INT : arb_type;
        sel_badv               = arb_badv;
        ctrl_if.commit_en      = 2'b00;
        ctrl_if.raise_excp     = 1'b0;
        ctrl_if.excp_type      = '0;
        ctrl_if.pc_in          = '0;
        ctrl_if.badv_we        = 1'b0;
        ctrl_if.badv_data      = '0;
        ctrl_if.vppn_we        = 1'b0;
        ctrl_if.vppn_data      = '0;
        ctrl_if.redirect_valid = 1'b0;
        ctrl_if.redirect_pc    = '0;
        ctrl_if.flush          = (state_q == ST_FLUSH);
        ctrl_if.stall          = (state_q == ST_IDLE);
        if (state_q == ST_RUN) ctrl_if.commit_en = arb_commit_en;
        if (trap_run || trap_idle) begin
            ctrl_if.raise_excp     = 1'b1;
            ctrl_if.excp_type      = sel_type;
            ctrl_if.pc_in          = trap_idle ? idle_pc_q : arb_pc;
            ctrl_if.redirect_valid = 1'b1;
            ctrl_if.redirect_pc    = ctrl_if.csr_pc_out;
            ctrl_if.flush          = 1'b1;
            if (!trap_idle && excp_sets_badv(sel_type)) begin
                ctrl_if.badv_we   = 1'b1;
                ctrl_if.badv_data = sel_badv;
            end
            if (!trap_idle && excp_sets_vppn(sel_type)) begin
                ctrl_if.vppn_we   = 1'b1;
                ctrl_if.vppn_data = sel_badv[31:13];
            end
        end
    end

endmodule

// File: tb/tb_excp_ctrl.sv
// Scoreboard bench for excp_ctrl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model.
module tb_excp_ctrl;
    import excp_ctrl_pkg::*;

    localparam int FLUSH_N = 2;

    typedef struct packed {
        logic [1:0]  ce;
        logic        raise;
        excp_t       ty;
        logic [31:0] pc_in;
        logic        bwe;
        logic [31:0] bdata;
        logic        vwe;
        logic [18:0] vdata;
        logic        rv;
        logic [31:0] rpc;
        logic        fl;
        logic        st;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    excp_ctrl_if bus ();
    excp_ctrl_if bus4 ();

    assign bus4.slot_valid     = bus.slot_valid;
    assign bus4.slot_pc        = bus.slot_pc;
    assign bus4.slot_excp      = bus.slot_excp;
    assign bus4.slot_excp_type = bus.slot_excp_type;
    assign bus4.slot_badv      = bus.slot_badv;
    assign bus4.slot_ertn      = bus.slot_ertn;
    assign bus4.slot_idle      = bus.slot_idle;
    assign bus4.csr_interrupt  = bus.csr_interrupt;
    assign bus4.csr_pc_out     = bus.csr_pc_out;

    excp_ctrl dut (.clk_i(clk), .reset_i(reset), .ctrl_if(bus));
    excp_ctrl #(.FLUSH_CYCLES(4)) dut4 (.clk_i(clk), .reset_i(reset), .ctrl_if(bus4));

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;
    int          m_flush_left = 0;
    bit          m_idle = 0;
    logic [31:0] m_idle_pc = '0;

    excp_t codes[13] = '{INT, PIL, PIS, PIF, PME, PPI, ADEF, ADEM, ALE, SYS, BRK, INE, IPE};
    logic [5:0] badv_codes[8] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h09, 6'h3f};
    logic [5:0] vppn_codes[6] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h3f};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t trap(input excp_t ty, input logic [31:0] pc, input logic [31:0] badv);
        exp_t e = '0;
        e.raise = 1; e.ty = ty; e.pc_in = pc; e.rv = 1; e.rpc = bus.csr_pc_out; e.fl = 1;
        foreach (badv_codes[i]) if (ty.ecode == badv_codes[i]) begin e.bwe = 1; e.bdata = badv; end
        foreach (vppn_codes[i]) if (ty.ecode == vppn_codes[i]) begin e.vwe = 1; e.vdata = badv[31:13]; end
        return e;
    endfunction

    // Reference model: derives this cycle's response from the inputs just driven.
    task automatic model_push();
        exp_t e = '0;
        logic [1:0] v = bus.slot_valid;
        if (m_flush_left > 0) begin
            e.fl = 1;
            m_flush_left--;
        end else if (m_idle) begin
            if (bus.csr_interrupt) begin
                e = trap(INT, m_idle_pc, 32'h0);
                m_idle = 0;
                m_flush_left = FLUSH_N - 1;
            end
            e.st = 1;
        end else begin
            if (v[0] && bus.csr_interrupt) e = trap(INT, bus.slot_pc[0], bus.slot_badv[0]);
            else if (v[0] && bus.slot_excp[0])
                e = trap(bus.slot_excp_type[0], bus.slot_pc[0], bus.slot_badv[0]);
            else if (v[0] && bus.slot_ertn[0]) e = trap(ERTN, bus.slot_pc[0], bus.slot_badv[0]);
            else if (v[0] && bus.slot_idle[0]) begin
                e.ce = 2'b01; m_idle = 1; m_idle_pc = bus.slot_pc[0] + 32'd4;
            end else if (v[1] && (bus.slot_excp[1] || bus.slot_ertn[1])) begin
                e = trap(bus.slot_excp[1] ? bus.slot_excp_type[1] : ERTN, bus.slot_pc[1], bus.slot_badv[1]);
                e.ce = 2'b01;
            end else if (v[1] && bus.slot_idle[1]) begin
                e.ce = 2'b11; m_idle = 1; m_idle_pc = bus.slot_pc[1] + 32'd4;
            end else e.ce = {v[1] & v[0], v[0]};
            if (e.raise) m_flush_left = FLUSH_N - 1;
        end
        expq.push_back(e);
    endtask

    task automatic clear_in();
        bus.slot_valid = '0; bus.slot_pc = '0; bus.slot_excp = '0; bus.slot_excp_type = '0;
        bus.slot_badv = '0; bus.slot_ertn = '0; bus.slot_idle = '0;
        bus.csr_interrupt = 0; bus.csr_pc_out = '0;
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        clear_in();
    endtask

    // Monitor: the DUT presents a response every cycle; compare away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("commit_en", 32'(bus.commit_en), 32'(e.ce));
                chk("raise_excp", 32'(bus.raise_excp), 32'(e.raise));
                chk("excp_type", 32'(bus.excp_type), 32'(e.ty));
                chk("pc_in", bus.pc_in, e.pc_in);
                chk("badv_we", 32'(bus.badv_we), 32'(e.bwe));
                chk("badv_data", bus.badv_data, e.bdata);
                chk("vppn_we", 32'(bus.vppn_we), 32'(e.vwe));
                chk("vppn_data", 32'(bus.vppn_data), 32'(e.vdata));
                chk("redirect_valid", 32'(bus.redirect_valid), 32'(e.rv));
                chk("redirect_pc", bus.redirect_pc, e.rpc);
                chk("flush", 32'(bus.flush), 32'(e.fl));
                chk("stall", 32'(bus.stall), 32'(e.st));
            end
        end
    end

    initial begin
        int r;
        reset = 1;
        clear_in();
        cyc_begin(); model_push();        // outputs while held in reset
        #5 reset = 0;

        // slot0 ALE
        cyc_begin();
        bus.slot_valid = 2'b01; bus.slot_pc[0] = 32'h1c00_0100; bus.slot_excp[0] = 1;
        bus.slot_excp_type[0] = ALE; bus.slot_badv[0] = 32'h1000_0003; bus.csr_pc_out = 32'h1c00_8000;
        model_push();
        cyc_begin(); bus.slot_valid = 2'b11; model_push();   // still flushing
        cyc_begin(); model_push();

        // slot0 clean, slot1 TLBR
        cyc_begin();
        bus.slot_valid = 2'b11; bus.slot_pc[0] = 32'h1c00_0110; bus.slot_pc[1] = 32'h1c00_0114;
        bus.slot_excp[1] = 1; bus.slot_excp_type[1] = TLBR; bus.slot_badv[1] = 32'h8000_2000;
        bus.csr_pc_out = 32'h1c00_f000;
        model_push();
        cyc_begin(); model_push();

        // interrupt beats slot0 SYS
        cyc_begin();
        bus.slot_valid = 2'b01; bus.slot_pc[0] = 32'h1c00_0120; bus.slot_excp[0] = 1;
        bus.slot_excp_type[0] = SYS; bus.csr_interrupt = 1; bus.csr_pc_out = 32'h1c00_9000;
        model_push();
        cyc_begin(); model_push();

        // idle, then interrupt after 5 stalled cycles
        cyc_begin();
        bus.slot_valid = 2'b11; bus.slot_pc[0] = 32'h1c00_0200; bus.slot_idle[0] = 1;
        model_push();
        for (int i = 0; i < 5; i++) begin
            cyc_begin(); bus.slot_valid = 2'b11; bus.slot_excp[0] = 1; model_push();
        end
        cyc_begin(); bus.csr_interrupt = 1; bus.csr_pc_out = 32'h1c00_a000; model_push();
        cyc_begin(); model_push();

        // slot1 ertn
        cyc_begin();
        bus.slot_valid = 2'b11; bus.slot_pc[0] = 32'h1c00_0300; bus.slot_pc[1] = 32'h1c00_0304;
        bus.slot_ertn[1] = 1; bus.csr_pc_out = 32'h1c00_0300;
        model_push();
        cyc_begin(); model_push();

        // reset in the middle of a 4-cycle flush
        cyc_begin();
        bus.slot_valid = 2'b01; bus.slot_pc[0] = 32'h1c00_0400; bus.slot_excp[0] = 1;
        bus.slot_excp_type[0] = SYS;
        model_push();
        cyc_begin(); model_push();
        #5 chk("flush4_before_reset", 32'(bus4.flush), 32'd1);
        reset = 1;
        #2;
        chk("flush4_async_drop", 32'(bus4.flush), 32'd0);
        chk("stall4_async_drop", 32'(bus4.stall), 32'd0);
        chk("flush_async_drop", 32'(bus.flush), 32'd0);
        m_flush_left = 0; m_idle = 0; m_idle_pc = '0;
        @(negedge clk);
        reset = 0;
        clear_in();
        bus.slot_valid = 2'b11; bus.slot_pc[0] = 32'h1c00_0500; bus.slot_pc[1] = 32'h1c00_0504;
        model_push();
        #3 chk("commit4_after_reset", 32'(bus4.commit_en), 32'd3);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            cyc_begin();
            r = $urandom_range(0, 9);
            bus.slot_valid = (r < 2) ? 2'b00 : (r < 5) ? 2'b01 : 2'b11;
            for (int i = 0; i < 2; i++) begin
                bus.slot_pc[i]        = 32'h1c00_0000 | ($urandom & 32'h0000_fffc);
                bus.slot_badv[i]      = $urandom;
                bus.slot_excp[i]      = ($urandom_range(0, 5) == 0);
                bus.slot_excp_type[i] = codes[$urandom_range(0, 12)];
                if ($urandom_range(0, 3) == 0) bus.slot_excp_type[i] = TLBR;
                bus.slot_ertn[i]      = ($urandom_range(0, 11) == 0);
                bus.slot_idle[i]      = ($urandom_range(0, 15) == 0);
            end
            bus.csr_interrupt = ($urandom_range(0, 7) == 0);
            bus.csr_pc_out    = $urandom;
            model_push();
        end

        cyc_begin();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
